// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline register file: default widths, zero-register
// index and the layout of the per-register change mask (GPRs, then HI, then LO).
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int ZERO_REG   = 0;

    function automatic int hi_idx(input int num_gpr);
        return num_gpr;
    endfunction

    function automatic int lo_idx(input int num_gpr);
        return num_gpr + 1;
    endfunction

    function automatic int mask_w(input int num_gpr);
        return num_gpr + 2;
    endfunction

    localparam int MASK_W_DEF = mask_w(32);

endpackage

// File: rtl/change_mask_acc.sv
// Accumulates per-register change bits between snapshot strobes and counts
// snapshots with a saturating counter.
module change_mask_acc
    import pipe_pkg::*;
#(
    parameter int MASK_W = MASK_W_DEF,
    parameter int CNT_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MASK_W-1:0] chg,
    input  logic              snap_en,
    output logic [MASK_W-1:0] change_mask,
    output logic [CNT_W-1:0]  cycle_cnt
);

    logic [MASK_W-1:0] pending;

    // Pending resets to all ones so the first snapshot after reset is a full dump.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending     <= '1;
            change_mask <= '0;
            cycle_cnt   <= '0;
        end else if (snap_en) begin
            change_mask <= pending | chg;
            pending     <= '0;
            if (cycle_cnt != '1) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
        end else begin
            pending <= pending | chg;
        end
    end

endmodule

// File: rtl/pipe_regfile_snap.sv
// Architectural register file (GPRs + HI/LO) with snapshot change tracking.
// Define RF_BYPASS_EN to forward same-cycle writes onto the read ports and hi/lo.
module pipe_regfile_snap
    import pipe_pkg::*;
#(
    parameter int NUM_GPR      = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int REG_AW       = REG_AW_DEF,
    parameter int CNT_W        = 20
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [REG_AW-1:0]              waddr,
    input  logic [DATA_W-1:0]              wdata,
    input  logic                           hilo_we,
    input  logic [DATA_W-1:0]              hi_wdata,
    input  logic [DATA_W-1:0]              lo_wdata,
    input  logic [NUM_RD_PORTS*REG_AW-1:0] raddr,
    output logic [NUM_RD_PORTS*DATA_W-1:0] rdata,
    output logic [DATA_W-1:0]              hi,
    output logic [DATA_W-1:0]              lo,
    input  logic                           snap_en,
    output logic [NUM_GPR+1:0]             change_mask,
    output logic [CNT_W-1:0]               cycle_cnt
);

    localparam int MW   = mask_w(NUM_GPR);
    localparam int HI_B = hi_idx(NUM_GPR);
    localparam int LO_B = lo_idx(NUM_GPR);

    logic [DATA_W-1:0] gpr [NUM_GPR];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              wr_eff;
    logic [MW-1:0]     chg;
    logic [REG_AW-1:0] ra;

    assign wr_eff = we && (waddr != REG_AW'(ZERO_REG)) && (32'(waddr) < 32'(NUM_GPR));

    // A bit is raised only when the stored value actually changes.
    always_comb begin
        chg = '0;
        for (int i = 1; i < NUM_GPR; i++) begin
            chg[i] = wr_eff && (waddr == REG_AW'(i)) && (wdata != gpr[i]);
        end
        chg[HI_B] = hilo_we && (hi_wdata != hi_q);
        chg[LO_B] = hilo_we && (lo_wdata != lo_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            for (int i = 1; i < NUM_GPR; i++) begin
                if (wr_eff && (waddr == REG_AW'(i))) begin
                    gpr[i] <= wdata;
                end
            end
            if (hilo_we) begin
                hi_q <= hi_wdata;
                lo_q <= lo_wdata;
            end
        end
    end

    // Address 0 and out-of-range addresses match no entry and read as zero.
    always_comb begin
        rdata = '0;
        ra    = '0;
        for (int k = 0; k < NUM_RD_PORTS; k++) begin
            ra = raddr[k*REG_AW +: REG_AW];
            for (int i = 1; i < NUM_GPR; i++) begin
                if (ra == REG_AW'(i)) begin
                    rdata[k*DATA_W +: DATA_W] = gpr[i];
                end
            end
`ifdef RF_BYPASS_EN
            if (wr_eff && (ra == waddr)) begin
                rdata[k*DATA_W +: DATA_W] = wdata;
            end
`endif
        end
    end

`ifdef RF_BYPASS_EN
    assign hi = hilo_we ? hi_wdata : hi_q;
    assign lo = hilo_we ? lo_wdata : lo_q;
`else
    assign hi = hi_q;
    assign lo = lo_q;
`endif

    change_mask_acc #(
        .MASK_W (MW),
        .CNT_W  (CNT_W)
    ) u_acc (
        .clk         (clk),
        .rst         (rst),
        .chg         (chg),
        .snap_en     (snap_en),
        .change_mask (change_mask),
        .cycle_cnt   (cycle_cnt)
    );

endmodule

// File: doc/pipe_regfile_snap.md
Name: pipe_regfile_snap

Overview:
Parametrised architectural register file for the MIPS-subset pipeline: NUM_GPR general registers plus HI/LO, NUM_RD_PORTS combinational read ports and one GPR write port plus one HI/LO write port. It generalises the snapshot register-print logic into synthesizable RTL:
- accumulates a per-register change mask between snapshot strobes;
- counts reported snapshots.

It sits beside the ID stage (reads) and the WB stage (writes) and feeds the snapshot/debug dumper.

Parameters:
NUM_GPR, 32, number of general registers; 2..32; index 0 hardwired to zero.
NUM_RD_PORTS, 2, number of independent read ports (1..4).
DATA_W, 32, register data width.
REG_AW, 5, register address width; must satisfy 2**REG_AW >= NUM_GPR.
CNT_W, 20, snapshot cycle counter width.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-low reset.
we  in  1  GPR write enable (WB stage).
waddr  in  REG_AW  GPR write address.
wdata  in  DATA_W  GPR write data.
hilo_we  in  1  HI and LO written together.
hi_wdata  in  DATA_W  HI write data.
lo_wdata  in  DATA_W  LO write data.
raddr  in  NUM_RD_PORTS*REG_AW  packed read addresses; port k uses slice k.
rdata  out  NUM_RD_PORTS*DATA_W  packed read data.
hi  out  DATA_W  current HI.
lo  out  DATA_W  current LO.
snap_en  in  1  snapshot strobe, one per reported cycle.
change_mask  out  NUM_GPR+2  bit i = GPR i changed; bit NUM_GPR = HI; bit NUM_GPR+1 = LO.
cycle_cnt  out  CNT_W  number of snapshots taken.

Behaviour:
Reset (rst low, asynchronous):
- All GPRs, HI, LO cleared to 0.
- Pending mask set to all ones; change_mask = 0; cycle_cnt = 0.
- Reset asserted mid-operation discards any in-flight write and accumulated mask.

GPR write:
- Occurs at posedge when we=1 and waddr!=0 and waddr<NUM_GPR.
- Writes to 0 or to out-of-range addresses are ignored and never set a mask bit.

HI/LO write:
- Both are written at posedge when hilo_we=1.
- Independent of we; both writes may occur in the same cycle.

Read:
- Combinational; raddr 0 or out-of-range returns 0.
- Without the optional feature, reading an address written in the same cycle returns the old value (write lands at the edge).

Change detection:
- A mask bit is set pending only if the write is effective AND the new value differs from the stored value.
- Rewriting an identical value sets no bit.

Snapshot, at posedge with snap_en=1:
- change_mask <= pending | this-cycle changes.
- Pending clears to 0.
- cycle_cnt increments, saturating at all ones.

No snapshot, at posedge with snap_en=0:
- pending |= this-cycle changes.
- change_mask and cycle_cnt hold.

Other rules:
- First snapshot after reset reports all ones: full dump at cycle 0.
- Simultaneous snapshot and write: the write is included in that snapshot, never double-counted in the next one.
- Latency: a write at edge N is visible on rdata after edge N. It is visible in change_mask after the first snap_en edge at or after N.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: write-through forwarding. A read whose address matches an effective same-cycle write returns wdata. hi/lo outputs forward hi_wdata/lo_wdata when hilo_we=1.
- Undefined: no forwarding. Reads return stored values only; the pipeline forwarding unit must cover WB→ID hazards.
- Mask and counter behaviour are identical in both builds.

Decomposition:
Shared package pipe_pkg:
- DATA_W and REG_AW defaults;
- HI_IDX/LO_IDX mask offsets as functions of NUM_GPR;
- the NUM_GPR+2 mask width constant;
- the ZERO_REG constant.

Sub-module change_mask_acc (natural split):
- Takes per-cycle change vector and snap_en.
- Owns pending register, change_mask and the saturating cycle_cnt.
- The top module holds storage and read muxing.

Test Plan:
1. Release rst, one snap_en -> change_mask=all ones (34 bits), cycle_cnt=1; all rdata=0.
2. we=1, waddr=5, wdata=0x0000_00A5, snap_en=1 -> next cycle rdata(raddr=5)=0xA5, change_mask=bit5 only. Repeat identical write -> change_mask=0.
3. we=1, waddr=0, wdata=0xFFFF_FFFF -> rdata(raddr=0)=0, change_mask bit0=0.
4. snap_en=0 for 3 cycles with writes to regs 3, 7 and hilo (HI=0x1, LO=0x2), then snap_en=1 -> change_mask = bits 3, 7, 32, 33; next snapshot = 0.
5. Same-cycle write reg 9=0x1234 and read port1 raddr=9 -> old value without RF_BYPASS_EN, 0x1234 with it.
6. Assert rst mid-run after 10 snapshots with pending bits -> outputs zero immediately (async); first post-reset snapshot = all ones, cycle_cnt=1. Separately, force cycle_cnt to the CNT_W all-ones value -> it stays saturated.
